// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode constants and slice sizing for the pipelined adder
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational ripple of W_S full-adder cells
module adder_slice #(
  parameter int W_S = 4
) (
  input  logic [W_S-1:0] a,
  input  logic [W_S-1:0] b,
  input  logic           cin,
  output logic [W_S-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [W_S:0]   c;
  logic [W_S-1:0] p;

  assign c[0] = cin;

  for (genvar i = 0; i < W_S; i++) begin : g_cell
    assign p[i]   = a[i] ^ b[i];
    assign s[i]   = p[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
  end

  assign cout     = c[W_S];
  assign c_msb_in = c[W_S-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep carry-pipelined add/subtract with valid/ready
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int W_S = slice_width(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic advance;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage k holds the low (k+1)*W_S sum bits plus the not-yet-added operand bits above them.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int H_IN = WIDTH - k * W_S;
    localparam int LO   = (k + 1) * W_S;

    logic [H_IN-1:0] src_a;
    logic [H_IN-1:0] src_b;
    logic            src_c;
    logic            src_v;
    logic [LO-1:0]   nxt_s;
    logic [W_S-1:0]  slice_s;
    logic            slice_co;
    logic            slice_cm;
    logic            v_q;
    logic            c_q;
    logic [LO-1:0]   s_q;

    if (k == 0) begin : g_head
      assign src_a = a;
      assign src_b = (sub == MODE_SUB) ? ~b : b;
      assign src_c = (sub == MODE_SUB) ? 1'b1 : cin;
      assign src_v = in_valid;
      assign nxt_s = slice_s;
    end else begin : g_body
      assign src_a = g_stage[k-1].g_skew.a_q;
      assign src_b = g_stage[k-1].g_skew.b_q;
      assign src_c = g_stage[k-1].c_q;
      assign src_v = g_stage[k-1].v_q;
      assign nxt_s = {slice_s, g_stage[k-1].s_q};
    end

    adder_slice #(.W_S(W_S)) u_slice (
      .a        (src_a[W_S-1:0]),
      .b        (src_b[W_S-1:0]),
      .cin      (src_c),
      .s        (slice_s),
      .cout     (slice_co),
      .c_msb_in (slice_cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= src_v;
        if (src_v) begin
          c_q <= slice_co;
          s_q <= nxt_s;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [H_IN-W_S-1:0] a_q;
      logic [H_IN-W_S-1:0] b_q;
      logic                unused_cm;

      assign unused_cm = slice_cm;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && src_v) begin
          a_q <= src_a[H_IN-1:W_S];
          b_q <= src_b[H_IN-1:W_S];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance && src_v) begin
          ovf_q <= slice_co ^ slice_cm;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed bench for pipelined_adder at 8/2, 16/1 and 16/4
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a, b;
  logic        cin, sub, in_valid, out_ready;
  int          sel;
  int          checks, errors;

  logic iv0, iv1, iv2;
  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  logic        ir0, ov0, co0, of0;
  logic [7:0]  s0;
  logic        ir1, ov1, co1, of1;
  logic [15:0] s1;
  logic        ir2, ov2, co2, of2;
  logic [15:0] s2;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_w8s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0)
  );
  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_w16s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1)
  );
  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_w16s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2)
  );

  logic        cur_ir, cur_ov, cur_co, cur_of;
  logic [15:0] cur_sum;

  always_comb begin
    cur_ir  = ir0;
    cur_ov  = ov0;
    cur_co  = co0;
    cur_of  = of0;
    cur_sum = {8'h00, s0};
    case (sel)
      1: begin cur_ir = ir1; cur_ov = ov1; cur_co = co1; cur_of = of1; cur_sum = s1; end
      2: begin cur_ir = ir2; cur_ov = ov2; cur_co = co2; cur_of = of2; cur_sum = s2; end
      default: ;
    endcase
  end

  function automatic int stages_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 4;
  endfunction

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : 16;
  endfunction

  // Reference: plain integer add on an extended width, overflow from operand/result signs.
  function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [16:0] t;
    logic [15:0] m, xe, ye;
    logic        co, ov;
    m  = (w == 16) ? 16'hFFFF : 16'h00FF;
    xe = x & m;
    ye = (s ? ~y : y) & m;
    t  = {1'b0, xe} + {1'b0, ye} + (s ? 17'd1 : {16'd0, c});
    co = (w == 16) ? t[16] : t[8];
    ov = (xe[w-1] == ye[w-1]) && (t[w-1] != xe[w-1]);
    return {ov, co, t[15:0] & m};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          sel;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;

  vec_t vecs [19];

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    sel       = v.sel;
    out_ready = 1'b1;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    #1 check($sformatf("v%0d_in_ready", idx), cur_ir, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!cur_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, stages_of(v.sel));
    check($sformatf("v%0d_sum", idx), cur_sum, v.sum);
    check($sformatf("v%0d_cout", idx), cur_co, v.cout);
    check($sformatf("v%0d_ovf", idx), cur_of, v.ovf);
  endtask

  task automatic run_stream(input int s_sel);
    logic [15:0] ea [4];
    logic [15:0] eb [4];
    logic        es [4];
    logic [17:0] ex [4];
    int sent, got, cyc, held, last_take;
    drain();
    sel = s_sel; out_ready = 1'b0; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ea[i] = 16'h1234 * 16'(i + 3);
      eb[i] = 16'hF00F ^ (16'h0101 * 16'(i));
      es[i] = i[0];
      ex[i] = model(width_of(s_sel), ea[i], eb[i], 1'b1, es[i]);
    end
    sent = 0; got = 0; cyc = 0; held = 0; last_take = 0;
    while (got < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cur_ov && !out_ready) begin
        held++;
        check($sformatf("s%0d_held_sum", s_sel), cur_sum, ex[0][15:0]);
        check($sformatf("s%0d_full_in_ready", s_sel), cur_ir, 0);
        if (held == 3) out_ready = 1'b1;
      end
      if (cur_ov && out_ready) begin
        check($sformatf("s%0d_b%0d_sum", s_sel, got), cur_sum, ex[got][15:0]);
        check($sformatf("s%0d_b%0d_cout", s_sel, got), cur_co, ex[got][16]);
        check($sformatf("s%0d_b%0d_ovf", s_sel, got), cur_of, ex[got][17]);
        if (got > 0) check($sformatf("s%0d_b%0d_gap", s_sel, got), cyc - last_take, 1);
        last_take = cyc;
        got++;
      end
      if (sent < 4) begin
        a = ea[sent]; b = eb[sent]; sub = es[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && cur_ir) sent++;
    end
    in_valid = 1'b0;
    check($sformatf("s%0d_held_cycles", s_sel), held, 3);
    check($sformatf("s%0d_drained", s_sel), got, 4);
  endtask

  task automatic run_reset_mid(input int s_sel, input int idx);
    int seen;
    drain();
    sel = s_sel; out_ready = 1'b0;
    @(negedge clk);
    a = 16'h0101; b = 16'h0202; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0303;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1 check($sformatf("r%0d_async_out_valid", s_sel), cur_ov, 0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1 check($sformatf("r%0d_in_ready", s_sel), cur_ir, 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (cur_ov) seen++;
    end
    check($sformatf("r%0d_flushed", s_sel), seen, 0);
    run_vec(vecs[idx], idx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    sel = 0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; rst_n = 1'b0;

    vecs[0]  = '{0, 16'h003C, 16'h0005, 1'b1, 1'b0, 16'h0042, 1'b0, 1'b0};
    vecs[1]  = '{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
    vecs[3]  = '{0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0};
    vecs[4]  = '{0, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1};
    vecs[5]  = '{0, 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{0, 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{0, 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[8]  = '{1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[10] = '{1, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[11] = '{1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[12] = '{1, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[13] = '{2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[14] = '{2, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[16] = '{2, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[17] = '{2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[18] = '{2, 16'h3C3C, 16'h0505, 1'b1, 1'b0, 16'h4142, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("rst%0d_out_valid", s), cur_ov, 0);
      check($sformatf("rst%0d_sum", s), cur_sum, 0);
      check($sformatf("rst%0d_cout", s), cur_co, 0);
      check($sformatf("rst%0d_ovf", s), cur_of, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 check($sformatf("rst%0d_in_ready", s), cur_ir, 1);
    end

    for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

    for (int s = 0; s < 3; s++) run_stream(s);

    run_reset_mid(0, 0);
    run_reset_mid(1, 8);
    run_reset_mid(2, 13);

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
